// File: rtl/afe_ppg_model_pkg.sv
// rtl/afe_ppg_model_pkg.sv - shared widths and saturation helpers for the AFE model
package afe_model_pkg;

  localparam int ADC_W   = 8;
  localparam int RESID_W = 16;
  localparam int AMP_W   = 24;
  localparam int ADC_MID = 128;
  localparam logic [3:0] GAIN_MAX = 4'd7;

  function automatic logic [ADC_W-1:0] sat_adc(input logic signed [AMP_W-1:0] amp);
    logic signed [AMP_W-1:0] v;
    v = amp + AMP_W'(ADC_MID);
    if (v[AMP_W-1])
      return '0;
    else if (v > AMP_W'(255))
      return '1;
    else
      return v[ADC_W-1:0];
  endfunction

  function automatic logic [2:0] clamp_gain(input logic [3:0] code);
    return (code > GAIN_MAX) ? 3'(GAIN_MAX) : code[2:0];
  endfunction

endpackage

// File: rtl/afe_ppg_model_if.sv
// rtl/afe_ppg_model_if.sv - controller-to-AFE bundle: LED/comp/gain drive and ADC return
interface afe_ppg_model_if;
  logic       LED_IR;
  logic       LED_RED;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] ADC;
  logic       adc_valid;

  modport master (output LED_IR, LED_RED, DC_Comp, PGA_Gain, input ADC, adc_valid);
  modport slave  (input LED_IR, LED_RED, DC_Comp, PGA_Gain, output ADC, adc_valid);
endinterface

// File: rtl/afe_ppg_model_wave_gen.sv
// rtl/afe_ppg_model_wave_gen.sv - triangle PPG generator; ac outputs always match the live phase
module ppg_wave_gen #(
  parameter int PERIOD_LOG2 = 10,
  parameter int AC_IR_AMP   = 32,
  parameter int AC_RED_AMP  = 24
) (
  input  logic              clk,
  input  logic              rst,
  output logic signed [9:0] ac_ir,
  output logic signed [9:0] ac_red
);

  logic [PERIOD_LOG2-1:0] phase;
  logic [PERIOD_LOG2-1:0] phase_nxt;

  function automatic logic signed [9:0] ac_of(input logic [PERIOD_LOG2-1:0] ph, input int amp);
    int ph_i;
    int tri_v;
    ph_i  = int'(ph);
    tri_v = (ph_i < (1 << (PERIOD_LOG2-1))) ? ph_i : (1 << PERIOD_LOG2) - ph_i;
    return 10'(((tri_v * amp) >>> (PERIOD_LOG2-1)) - (amp >>> 1));
  endfunction

  always_comb phase_nxt = phase + PERIOD_LOG2'(1);

  // ac is registered from the next phase so it lines up with phase itself
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= '0;
      ac_ir  <= ac_of('0, AC_IR_AMP);
      ac_red <= ac_of('0, AC_RED_AMP);
    end else begin
      phase  <= phase_nxt;
      ac_ir  <= ac_of(phase_nxt, AC_IR_AMP);
      ac_red <= ac_of(phase_nxt, AC_RED_AMP);
    end
  end

endmodule

// File: rtl/afe_ppg_model.sv
// rtl/afe_ppg_model.sv - two-stage AFE model: source/DC-comp/gain, then shift, saturate and blank
module afe_ppg_model
  import afe_model_pkg::*;
#(
  parameter int DC_IR_LEVEL  = 520,
  parameter int DC_RED_LEVEL = 430,
  parameter int AC_IR_AMP    = 32,
  parameter int AC_RED_AMP   = 24,
  parameter int PERIOD_LOG2  = 10,
  parameter int COMP_STEP    = 8,
  parameter int OUT_SHIFT    = 3,
  parameter int BLANK_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  afe_ppg_model_if.slave  afe
);

  logic signed [9:0]         ac_ir;
  logic signed [9:0]         ac_red;
  logic signed [RESID_W-1:0] src;
  logic signed [RESID_W-1:0] resid_d;
  logic signed [RESID_W-1:0] resid_q;
  logic        [2:0]         gain_q;
  logic        [1:0]         led_q;
  logic        [1:0]         led_now;
  logic        [3:0]         blank_cnt;
  logic        [1:0]         fill_cnt;
  logic signed [AMP_W-1:0]   amp;

  ppg_wave_gen #(
    .PERIOD_LOG2 (PERIOD_LOG2),
    .AC_IR_AMP   (AC_IR_AMP),
    .AC_RED_AMP  (AC_RED_AMP)
  ) u_wave (
    .clk    (clk),
    .rst    (rst),
    .ac_ir  (ac_ir),
    .ac_red (ac_red)
  );

  always_comb begin
    led_now = {afe.LED_IR, afe.LED_RED};
    src     = '0;
    if (afe.LED_IR)
      src = src + RESID_W'(DC_IR_LEVEL) + RESID_W'(ac_ir);
    if (afe.LED_RED)
      src = src + RESID_W'(DC_RED_LEVEL) + RESID_W'(ac_red);
    resid_d = src - RESID_W'(int'(afe.DC_Comp) * COMP_STEP);
  end

  always_comb amp = (AMP_W'(resid_q) <<< gain_q) >>> OUT_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      resid_q       <= '0;
      gain_q        <= '0;
      led_q         <= '0;
      blank_cnt     <= '0;
      fill_cnt      <= '0;
      afe.ADC       <= ADC_W'(ADC_MID);
      afe.adc_valid <= 1'b0;
    end else begin
      resid_q <= resid_d;
      gain_q  <= clamp_gain(afe.PGA_Gain);
      led_q   <= led_now;
      if (fill_cnt != 2'd2)
        fill_cnt <= fill_cnt + 2'd1;
      // a fresh LED change always reloads, so overlapping switches never stack
      if (led_now != led_q)
        blank_cnt <= 4'(BLANK_CYCLES);
      else if (blank_cnt != 4'd0)
        blank_cnt <= blank_cnt - 4'd1;
      if (blank_cnt != 4'd0 || fill_cnt != 2'd2) begin
        afe.ADC       <= ADC_W'(ADC_MID);
        afe.adc_valid <= 1'b0;
      end else begin
        afe.ADC       <= sat_adc(amp);
        afe.adc_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_afe_ppg_model.sv
// tb/tb_afe_ppg_model.sv - randomized and directed checks of afe_ppg_model against a history-based model
module tb_afe_ppg_model;

  localparam int P     = 4;
  localparam int AIR   = 32;
  localparam int ARED  = 24;
  localparam int DCIR  = 520;
  localparam int DCRED = 430;
  localparam int CSTEP = 8;
  localparam int OSH   = 3;
  localparam int BLANK = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  afe_ppg_model_if afe();

  afe_ppg_model #(
    .DC_IR_LEVEL  (DCIR),
    .DC_RED_LEVEL (DCRED),
    .AC_IR_AMP    (AIR),
    .AC_RED_AMP   (ARED),
    .PERIOD_LOG2  (P),
    .COMP_STEP    (CSTEP),
    .OUT_SHIFT    (OSH),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .afe (afe)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit ir;
    bit red;
    int comp;
    int gain;
  } in_t;

  in_t hist[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ac_of(input int ph, input int amp);
    int t;
    t = (ph < (1 << (P-1))) ? ph : (1 << P) - ph;
    return ((t * amp) >> (P-1)) - (amp >> 1);
  endfunction

  function automatic int sample_value(input in_t s, input int ph);
    int src, resid, g, a, v;
    src = 0;
    if (s.ir)  src += DCIR + ac_of(ph, AIR);
    if (s.red) src += DCRED + ac_of(ph, ARED);
    resid = src - s.comp * CSTEP;
    g = (s.gain > 7) ? 7 : s.gain;
    a = (resid * (1 << g)) >>> OSH;
    v = 128 + a;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  function automatic bit led_changed(input int j);
    bit [1:0] prev, cur;
    prev = (j == 0) ? 2'b00 : {hist[j-1].ir, hist[j-1].red};
    cur  = {hist[j].ir, hist[j].red};
    return prev != cur;
  endfunction

  // output after the e-th edge since reset release: blanked if any LED change in the last BLANK edges
  function automatic void expect_out(output int adc, output int vld);
    int e;
    bit blanked;
    e = hist.size() - 1;
    adc = 128;
    vld = 0;
    if (e < 2) return;
    blanked = 0;
    for (int j = e - BLANK; j <= e - 1; j++)
      if (j >= 0 && led_changed(j)) blanked = 1;
    if (blanked) return;
    adc = sample_value(hist[e-1], (e-1) % (1 << P));
    vld = 1;
  endfunction

  task automatic step(input bit r, input bit ir, input bit red, input int comp, input int gain,
                      output int got_adc, output int got_vld);
    in_t s;
    int exp_adc, exp_vld;
    @(negedge clk);
    rst          = r;
    afe.LED_IR   = ir;
    afe.LED_RED  = red;
    afe.DC_Comp  = 7'(comp);
    afe.PGA_Gain = 4'(gain);
    @(posedge clk);
    if (r) begin
      hist.delete();
      exp_adc = 128;
      exp_vld = 0;
    end else begin
      s.ir = ir; s.red = red; s.comp = comp; s.gain = gain;
      hist.push_back(s);
      expect_out(exp_adc, exp_vld);
    end
    #1;
    got_adc = int'(afe.ADC);
    got_vld = int'(afe.adc_valid);
    check_eq("adc", got_adc, exp_adc);
    check_eq("adc_valid", got_vld, exp_vld);
  endtask

  initial begin
    int a, v, mn, mx, inval;
    bit ir, red;
    int comp, gain;

    // reset and directed IR triangle sweep
    step(1, 0, 0, 0, 0, a, v);
    check_eq("reset_adc", a, 128);
    check_eq("reset_valid", v, 0);
    mn = 255; mx = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, 65, 3, a, v);
      if (v == 1) begin
        if (a < mn) mn = a;
        if (a > mx) mx = a;
      end
    end
    check_eq("tri_min", mn, 112);
    check_eq("tri_max", mx, 144);

    // saturation high with clamped gain code, then low
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 12, a, v);
    check_eq("sat_high", a, 255);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 127, 7, a, v);
    check_eq("sat_low", a, 0);

    // LED switch to RED: exactly BLANK invalid outputs afterwards
    for (int i = 0; i < 4; i++) step(0, 1, 0, 54, 0, a, v);
    step(0, 0, 1, 54, 0, a, v);
    inval = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 54, 0, a, v);
      if (v == 0) inval++;
    end
    check_eq("blank_len", inval, BLANK);

    // second toggle mid-blank restarts the window
    step(0, 1, 0, 54, 0, a, v);
    step(0, 1, 0, 54, 0, a, v);
    step(0, 0, 1, 54, 0, a, v);
    inval = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 54, 0, a, v);
      if (v == 0) inval++;
    end
    check_eq("reblank_len", inval, BLANK);

    // mid-run reset: valid returns on the third edge after release with LEDs off
    step(1, 0, 1, 54, 0, a, v);
    check_eq("midrst_adc", a, 128);
    check_eq("midrst_valid", v, 0);
    step(0, 0, 0, 10, 2, a, v);
    step(0, 0, 0, 10, 2, a, v);
    check_eq("fill_valid_e1", v, 0);
    step(0, 0, 0, 10, 2, a, v);
    check_eq("fill_valid_e2", v, 1);

    // randomized traffic
    ir = 1; red = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        ir  = 1'($urandom_range(1));
        red = 1'($urandom_range(1));
      end
      comp = ($urandom_range(3) == 0) ? int'($urandom_range(127)) : int'($urandom_range(70, 50));
      gain = int'($urandom_range(15));
      step($urandom_range(63) == 0, ir, red, comp, gain, a, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
